fifo_flops_mode: RTL and testbench
==================================

Name: fifo_flops_mode

Overview:
Parametrised flop-based synchronous FIFO. It is the next generation of the fifo_flops block and keeps the same Din/Dout/push/pop/full/pndng interface. It adds an occupancy count, almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a run-time selectable full-policy: drop the new word, or overwrite the oldest. It is used as the generic buffering element between agents and the DUT in the team's bus and test environments.

Parameters:
DEPTH, 16, number of entries; any integer >= 2 (power of two not required)
BITS, 16, data width in bits
AF_LVL, DEPTH-2, almost_full asserts when count >= AF_LVL (range 1..DEPTH)
AE_LVL, 2, almost_empty asserts when count <= AE_LVL (range 0..DEPTH-1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
Din  input  BITS  write data, sampled on clk when push=1
push  input  1  write request
pop  input  1  read request; consumes the head entry
ovr_mode  input  1  full-policy: 0 = drop incoming word, 1 = overwrite oldest
clr_err  input  1  synchronous clear of the overflow and underflow flags
Dout  output  BITS  head entry (first-word fall-through)
pndng  output  1  FIFO non-empty (count != 0)
full  output  1  count == DEPTH
count  output  $clog2(DEPTH+1)  current occupancy
almost_full  output  1  count >= AF_LVL
almost_empty  output  1  count <= AE_LVL
overflow  output  1  sticky; push attempted while full without a simultaneous pop
underflow  output  1  sticky; pop attempted while empty

Behaviour:
- Reset (rst=1 at clk edge): read and write pointers = 0, count = 0, overflow = 0, underflow = 0. Resulting outputs: pndng = 0, full = 0, almost_full = 0 (AF_LVL >= 1), almost_empty = 1, Dout = 0. The storage array is not cleared. Reset overrides push, pop and clr_err in the same cycle. Reset mid-operation discards all contents.
- Outputs pndng, full, count, almost_full and almost_empty are decoded from registered state, so they update one edge after the causing push or pop.
- Dout is combinational from storage[rd_ptr] when count != 0, and 0 when count == 0. No read latency: the head is visible as soon as pndng = 1. A pop at edge N makes the next entry visible after edge N.
- Pointers increment modulo DEPTH, wrapping from DEPTH-1 to 0. No power-of-two assumption.
- Per-edge action, evaluated on pre-edge count:
  - Idle: no change.
  - Push only, count < DEPTH: write Din at wr_ptr, wr_ptr++, count++.
  - Push only, count == DEPTH, ovr_mode = 0: word dropped, state unchanged, overflow <= 1.
  - Push only, count == DEPTH, ovr_mode = 1: write Din at wr_ptr, wr_ptr++, rd_ptr++ (oldest discarded), count stays DEPTH, overflow <= 1.
  - Pop only, count > 0: rd_ptr++, count--.
  - Pop only, count == 0: no state change, underflow <= 1.
  - Push + pop, 0 < count <= DEPTH: write and read both occur, both pointers ++, count unchanged, no error flag. Valid when full.
  - Push + pop, count == 0: push accepted (count becomes 1), pop ignored, underflow <= 1.
- clr_err = 1 clears overflow and underflow. If a new error event occurs in the same cycle, the set wins.
- ovr_mode is sampled per cycle and may change at any time.
- push and pop are level-sensitive. Each cycle they are high counts as one request.

Test Plan:
- Reset 5 cycles, then push 0..15 on consecutive edges (DEPTH=16) -> count steps 1..16; almost_full at count 14; full=1 after the 16th push; Dout=0 throughout; overflow=0.
- From full, ovr_mode=0, push 99 -> count=16, overflow=1. Then pop 16 times -> Dout sequence 0..15, pndng=0 after the last pop, almost_empty from count 2.
- From full holding 0..15, ovr_mode=1, push 100 and 101 -> count=16, overflow=1, Dout=2. Popping all yields 2..15,100,101.
- Empty FIFO: pop -> underflow=1, count=0. Then clr_err=1 -> underflow=0. Push+pop together on empty with Din=7 -> count=1, Dout=7, underflow=1.
- Full FIFO: push+pop each cycle with Din=200.. for 20 cycles -> count stays 16, full stays 1, no flags set, popped data in order 0..15 then 200..203.
- DEPTH=5: push 0..4, pop 3, push 5..7 (wrap) -> pops return 3,4,5,6,7. Separately, assert rst mid-fill at count=3 -> count=0, pndng=0, Dout=0 next cycle.

Source files
------------

// File: rtl/fifo_flops_mode.sv
// Flop-based synchronous FIFO with first-word fall-through, occupancy count,
// almost-full/empty thresholds, sticky error flags and a drop/overwrite full-policy.
module fifo_flops_mode #(
  parameter int DEPTH  = 16,
  parameter int BITS   = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] Din,
  input  logic            push,
  input  logic            pop,
  input  logic            ovr_mode,
  input  logic            clr_err,
  output logic [BITS-1:0] Dout,
  output logic            pndng,
  output logic            full,
  output logic [CW-1:0]   count,
  output logic            almost_full,
  output logic            almost_empty,
  output logic            overflow,
  output logic            underflow
);

  logic [BITS-1:0] mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            is_empty, is_full, wr_en, rd_adv, ovf_ev, unf_ev;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_empty = (count == '0);
  assign is_full  = (count == CW'(DEPTH));

  // A write lands when there is room, when a pop frees the head slot, or when
  // overwrite mode evicts the oldest entry; the eviction also advances rd_ptr.
  assign wr_en  = push && (!is_full || pop || ovr_mode);
  assign rd_adv = (pop && !is_empty) || (push && !pop && is_full && ovr_mode);
  assign ovf_ev = push && !pop && is_full;
  assign unf_ev = pop && is_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= inc(wr_ptr);
      if (rd_adv) rd_ptr <= inc(rd_ptr);
      count     <= count + CW'(wr_en) - CW'(rd_adv);
      overflow  <= ovf_ev | (overflow & ~clr_err);
      underflow <= unf_ev | (underflow & ~clr_err);
    end
  end

  // Storage is not reset; rst only has to block a concurrent write.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= Din;
  end

  assign Dout         = is_empty ? '0 : mem[rd_ptr];
  assign pndng        = !is_empty;
  assign full         = is_full;
  assign almost_full  = (count >= CW'(AF_LVL));
  assign almost_empty = (count <= CW'(AE_LVL));

endmodule

// File: tb/tb_fifo_flops_mode.sv
// Bench for fifo_flops_mode: DEPTH=16 and DEPTH=5 instances share stimulus and
// are compared against queue-based reference models plus directed expectations.
module tb_fifo_flops_mode;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, push = 1'b0, pop = 1'b0, ovr_mode = 1'b0, clr_err = 1'b0;
  logic [15:0] Din = '0;

  logic [15:0] a_dout, b_dout;
  logic [4:0]  a_count;
  logic [2:0]  b_count;
  logic a_pndng, a_full, a_af, a_ae, a_ovf, a_unf;
  logic b_pndng, b_full, b_af, b_ae, b_ovf, b_unf;

  fifo_flops_mode #(.DEPTH(16), .BITS(16)) dut_a (
    .clk(clk), .rst(rst), .Din(Din), .push(push), .pop(pop), .ovr_mode(ovr_mode),
    .clr_err(clr_err), .Dout(a_dout), .pndng(a_pndng), .full(a_full), .count(a_count),
    .almost_full(a_af), .almost_empty(a_ae), .overflow(a_ovf), .underflow(a_unf));

  fifo_flops_mode #(.DEPTH(5), .BITS(16)) dut_b (
    .clk(clk), .rst(rst), .Din(Din), .push(push), .pop(pop), .ovr_mode(ovr_mode),
    .clr_err(clr_err), .Dout(b_dout), .pndng(b_pndng), .full(b_full), .count(b_count),
    .almost_full(b_af), .almost_empty(b_ae), .overflow(b_ovf), .underflow(b_unf));

  wire [26:0] a_vec = {a_count, a_pndng, a_full, a_af, a_ae, a_ovf, a_unf, a_dout};
  wire [24:0] b_vec = {b_count, b_pndng, b_full, b_af, b_ae, b_ovf, b_unf, b_dout};

  typedef logic [15:0] q_t[$];
  q_t qa, qb;
  bit ovf_a, unf_a, ovf_b, unf_b;
  int errs = 0, checks = 0;

  // Reference: a FIFO is a queue; what happens to it depends only on its size.
  function automatic q_t nxt(input q_t q, input int dep, input bit ps, input bit pp,
                             input bit ov, input logic [15:0] d);
    q_t r;
    r = q;
    if (r.size() == 0) begin
      if (ps) r.push_back(d);
    end else if (ps && !pp && r.size() == dep) begin
      if (ov) begin void'(r.pop_front()); r.push_back(d); end
    end else begin
      if (pp) void'(r.pop_front());
      if (ps) r.push_back(d);
    end
    return r;
  endfunction

  function automatic logic [26:0] exp_a();
    int n = qa.size();
    return {5'(n), n != 0, n == 16, n >= 14, n <= 2, ovf_a, unf_a, (n != 0) ? qa[0] : 16'd0};
  endfunction

  function automatic logic [24:0] exp_b();
    int n = qb.size();
    return {3'(n), n != 0, n == 5, n >= 3, n <= 2, ovf_b, unf_b, (n != 0) ? qb[0] : 16'd0};
  endfunction

  task automatic cyc(input bit r, input bit ps, input bit pp, input logic [15:0] d,
                     input bit ov, input bit cl);
    rst = r; push = ps; pop = pp; Din = d; ovr_mode = ov; clr_err = cl;
    @(posedge clk);
    if (r) begin
      qa.delete(); qb.delete();
      ovf_a = 0; unf_a = 0; ovf_b = 0; unf_b = 0;
    end else begin
      ovf_a = (ovf_a && !cl) || (ps && !pp && qa.size() == 16);
      unf_a = (unf_a && !cl) || (pp && qa.size() == 0);
      ovf_b = (ovf_b && !cl) || (ps && !pp && qb.size() == 5);
      unf_b = (unf_b && !cl) || (pp && qb.size() == 0);
      qa = nxt(qa, 16, ps, pp, ov, d);
      qb = nxt(qb, 5, ps, pp, ov, d);
    end
    #1;
    rst = 0; push = 0; pop = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    cyc(0, 1, 0, 16'h55, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0, 0);
    checks++;
    if (a_vec !== {5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      errs++; $display("FAIL reset_a got %h want %h", a_vec, {5'd0, 6'b000100, 16'd0});
    end
    checks++;
    if (b_vec !== {3'd0, 6'b000100, 16'd0}) begin
      errs++; $display("FAIL reset_b got %h want %h", b_vec, {3'd0, 6'b000100, 16'd0});
    end
  endtask

  task automatic test_fill();
    logic [26:0] e;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 16'(i), 0, 0);
      e = {5'(i + 1), 1'b1, i == 15, i + 1 >= 14, i + 1 <= 2, 1'b0, 1'b0, 16'd0};
      checks++;
      if (a_vec !== e) begin errs++; $display("FAIL fill[%0d] got %h want %h", i, a_vec, e); end
    end
  endtask

  task automatic test_drop();
    cyc(0, 1, 0, 16'd99, 0, 0);
    checks++;
    if ({a_count, a_ovf, a_dout} !== {5'd16, 1'b1, 16'd0}) begin
      errs++; $display("FAIL drop_full got cnt=%0d ovf=%0d dout=%0d want 16 1 0", a_count, a_ovf, a_dout);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (a_dout !== 16'(i)) begin errs++; $display("FAIL drop_pop[%0d] got %0d want %0d", i, a_dout, i); end
      cyc(0, 0, 1, 0, 0, 0);
      checks++;
      if (a_ae !== (15 - i <= 2)) begin errs++; $display("FAIL drop_ae[%0d] got %0d want %0d", i, a_ae, 15 - i <= 2); end
    end
    checks++;
    if (a_pndng !== 1'b0) begin errs++; $display("FAIL drop_empty got pndng=%0d want 0", a_pndng); end
  endtask

  task automatic test_ovr();
    logic [15:0] e;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 16'(i), 0, 0);
    cyc(0, 1, 0, 16'd100, 1, 0);
    cyc(0, 1, 0, 16'd101, 1, 0);
    checks++;
    if ({a_count, a_ovf, a_dout} !== {5'd16, 1'b1, 16'd2}) begin
      errs++; $display("FAIL ovr_state got cnt=%0d ovf=%0d dout=%0d want 16 1 2", a_count, a_ovf, a_dout);
    end
    for (int i = 0; i < 16; i++) begin
      e = (i < 14) ? 16'(i + 2) : 16'(100 + i - 14);
      checks++;
      if (a_dout !== e) begin errs++; $display("FAIL ovr_pop[%0d] got %0d want %0d", i, a_dout, e); end
      cyc(0, 0, 1, 0, 0, 0);
    end
  endtask

  task automatic test_underflow();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    checks++;
    if ({a_unf, a_count} !== {1'b1, 5'd0}) begin
      errs++; $display("FAIL unf_set got unf=%0d cnt=%0d want 1 0", a_unf, a_count);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (a_unf !== 1'b0) begin errs++; $display("FAIL unf_clr got %0d want 0", a_unf); end
    cyc(0, 1, 1, 16'd7, 0, 0);
    checks++;
    if ({a_count, a_dout, a_unf} !== {5'd1, 16'd7, 1'b1}) begin
      errs++; $display("FAIL unf_pushpop got cnt=%0d dout=%0d unf=%0d want 1 7 1", a_count, a_dout, a_unf);
    end
    cyc(0, 1, 0, 16'd8, 0, 1);
    checks++;
    if (a_unf !== 1'b0) begin errs++; $display("FAIL unf_clr2 got %0d want 0", a_unf); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 16'(i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      e = (i < 16) ? 16'(i) : 16'(200 + i - 16);
      checks++;
      if (a_dout !== e) begin errs++; $display("FAIL b2b_dout[%0d] got %0d want %0d", i, a_dout, e); end
      cyc(0, 1, 1, 16'(200 + i), 0, 0);
      checks++;
      if ({a_count, a_full, a_ovf, a_unf} !== {5'd16, 1'b1, 1'b0, 1'b0}) begin
        errs++; $display("FAIL b2b_state[%0d] got cnt=%0d full=%0d ovf=%0d unf=%0d want 16 1 0 0",
                         i, a_count, a_full, a_ovf, a_unf);
      end
    end
  endtask

  task automatic test_depth5();
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 16'(i), 0, 0);
    checks++;
    if ({b_full, b_count} !== {1'b1, 3'd5}) begin
      errs++; $display("FAIL d5_full got full=%0d cnt=%0d want 1 5", b_full, b_count);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
    for (int i = 5; i < 8; i++) cyc(0, 1, 0, 16'(i), 0, 0);
    for (int i = 3; i < 8; i++) begin
      checks++;
      if (b_dout !== 16'(i)) begin errs++; $display("FAIL d5_wrap[%0d] got %0d want %0d", i, b_dout, i); end
      cyc(0, 0, 1, 0, 0, 0);
    end
    checks++;
    if ({b_pndng, b_ovf, b_unf} !== 3'b000) begin
      errs++; $display("FAIL d5_end got pndng=%0d ovf=%0d unf=%0d want 0 0 0", b_pndng, b_ovf, b_unf);
    end
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 16'(40 + i), 0, 0);
    checks++;
    if (b_count !== 3'd3) begin errs++; $display("FAIL d5_midfill got %0d want 3", b_count); end
    cyc(1, 1, 0, 16'd77, 0, 0);
    checks++;
    if ({b_count, b_pndng, b_dout} !== {3'd0, 1'b0, 16'd0}) begin
      errs++; $display("FAIL d5_midrst got cnt=%0d pndng=%0d dout=%0d want 0 0 0", b_count, b_pndng, b_dout);
    end
  endtask

  task automatic test_random();
    bit ps, pp, fillb;
    for (int k = 0; k < 800; k++) begin
      fillb = ((k / 60) % 2) == 0;
      ps = fillb ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      pp = fillb ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      cyc($urandom_range(0, 199) == 0, ps, pp, 16'($urandom), $urandom_range(0, 1) == 1,
          $urandom_range(0, 15) == 0);
      checks++;
      if (a_vec !== exp_a()) begin errs++; $display("FAIL rand_a[%0d] got %h want %h", k, a_vec, exp_a()); end
      checks++;
      if (b_vec !== exp_b()) begin errs++; $display("FAIL rand_b[%0d] got %h want %h", k, b_vec, exp_b()); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drop();
    test_ovr();
    test_underflow();
    test_back_to_back();
    test_depth5();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
